// File: rtl/regfile_rmw_master_pkg.sv
// Shared types for the register-file command master: FSM states, enable
// constants and the command/response records.
package regfile_master_pkg;

  localparam int CMD_ADDR_W = 5;
  localparam int CMD_DATA_W = 32;
  localparam int NBYTES     = 4;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [1:0] RD_BOTH = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RMW_RD,
    WR,
    RD,
    RESP
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [NBYTES-1:0]     be;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [CMD_DATA_W-1:0] rdata;
    logic                  err;
  } resp_t;

endpackage

// File: rtl/regfile_rmw_master_if.sv
// Command, response and register-file port bundle; the master modport is the
// view seen by regfile_rmw_master, the slave modport the surrounding system.
interface regfile_rmw_master_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        cmd_be;
  logic [DATA_W-1:0] cmd_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic [3:0]        rf_wen;
  logic [1:0]        rf_readwen;
  logic [ADDR_W-1:0] rf_raddr1;
  logic [ADDR_W-1:0] rf_raddr2;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata,
    input  resp_ready, rf_rdata1, rf_rdata2,
    output cmd_ready, resp_valid, resp_rdata, resp_err,
    output rf_wen, rf_readwen, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata,
    output resp_ready, rf_rdata1, rf_rdata2,
    input  cmd_ready, resp_valid, resp_rdata, resp_err,
    input  rf_wen, rf_readwen, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/regfile_rmw_master_byte_merge.sv
// Per-byte select between new write data and the current register contents.
module byte_merge
  import regfile_master_pkg::*;
(
  input  logic [NBYTES-1:0]   i_be,
  input  logic [8*NBYTES-1:0] i_new,
  input  logic [8*NBYTES-1:0] i_old,
  output logic [8*NBYTES-1:0] o_merged
);

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
    assign o_merged[8*gi +: 8] = i_be[gi] ? i_new[8*gi +: 8] : i_old[8*gi +: 8];
  end

endmodule

// File: rtl/regfile_rmw_master.sv
// Read / byte-masked-write command master for the 32x32 register file.
// Define RMW_MERGE_EN to preserve unmasked bytes via a read-modify-write pass.
module regfile_rmw_master
  import regfile_master_pkg::*;
#(
  parameter int ADDR_W = CMD_ADDR_W,
  parameter int DATA_W = CMD_DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_rmw_master_if.master bus
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_merge;
  resp_t             r_resp;
  cmd_t              w_cmd;
  logic [DATA_W-1:0] w_merged;
  logic              w_unused;

  assign w_cmd    = '{write: bus.cmd_write, addr: bus.cmd_addr, be: bus.cmd_be, wdata: bus.cmd_wdata};
  assign w_unused = &{1'b0, bus.rf_rdata2};

  // r_merge still holds the command's write data while in RMW_RD.
  byte_merge u_merge (
    .i_be     (r_be),
    .i_new    (r_merge),
    .i_old    (bus.rf_rdata1),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_be    <= '0;
      r_merge <= '0;
      r_resp  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_addr <= w_cmd.addr;
            r_be   <= w_cmd.be;
            r_resp <= '0;
            if (!w_cmd.write) begin
              r_state <= RD;
            end else if (w_cmd.addr == '0 || w_cmd.be == 4'h0) begin
              r_resp.err <= (w_cmd.addr == '0);
              r_state    <= RESP;
            end else if (w_cmd.be == BE_FULL) begin
              r_merge <= w_cmd.wdata;
              r_state <= WR;
            end else begin
              r_merge <= w_cmd.wdata;
`ifdef RMW_MERGE_EN
              r_state <= RMW_RD;
`else
              r_state <= WR;
`endif
            end
          end
        end
        RMW_RD: begin
          r_merge <= w_merged;
          r_state <= WR;
        end
        WR: r_state <= RESP;
        RD: begin
          r_resp.rdata <= (r_addr == '0) ? '0 : bus.rf_rdata1;
          r_state      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The file writes every edge, so idle cycles park the write on register 0.
  always_comb begin
    bus.rf_wen     = '0;
    bus.rf_readwen = '0;
    bus.rf_raddr1  = '0;
    bus.rf_waddr   = '0;
    bus.rf_wdata   = '0;
    case (r_state)
      RMW_RD: begin
        bus.rf_raddr1  = r_addr;
        bus.rf_readwen = RD_BOTH;
      end
      WR: begin
        bus.rf_waddr = r_addr;
        bus.rf_wdata = r_merge;
`ifdef RMW_MERGE_EN
        bus.rf_wen   = BE_FULL;
`else
        bus.rf_wen   = r_be;
`endif
      end
      RD: begin
        if (r_addr != '0) begin
          bus.rf_raddr1  = r_addr;
          bus.rf_readwen = RD_BOTH;
        end
      end
      default: ;
    endcase
  end

  assign bus.rf_raddr2  = '0;
  assign bus.cmd_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_resp.rdata;
  assign bus.resp_err   = r_resp.err;

endmodule

// File: tb/tb_regfile_rmw_master.sv
// Scoreboard bench for regfile_rmw_master with a behavioural register file.
module tb_regfile_rmw_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_rmw_master_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_rmw_master #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef RMW_MERGE_EN
  localparam int          LAT_PART = 3;
  localparam logic [31:0] EXP_RF7  = 32'h11BB33DD;
  localparam logic [31:0] EXP_RF9  = 32'h55667788;
`else
  localparam int          LAT_PART = 2;
  localparam logic [31:0] EXP_RF7  = 32'h00BB00DD;
  localparam logic [31:0] EXP_RF9  = 32'h0000CAFE;
`endif

  // Behavioural register file: writes every edge, disabled bytes become zero.
  logic [31:0] rf_mem [32];
  logic [31:0] rf_wword;
  logic        wrote0 = 1'b0;

  always_comb begin
    rf_wword = '0;
    for (int b = 0; b < 4; b++)
      rf_wword[8*b +: 8] = bus.rf_wen[b] ? bus.rf_wdata[8*b +: 8] : 8'h00;
  end

  always @(posedge clk) begin
    rf_mem[bus.rf_waddr] <= rf_wword;
    if (bus.rf_waddr == 5'd0 && bus.rf_wen != 4'h0) wrote0 <= 1'b1;
  end

  assign bus.rf_rdata1 = {bus.rf_readwen[1] ? rf_mem[bus.rf_raddr1][31:16] : 16'h0,
                          bus.rf_readwen[0] ? rf_mem[bus.rf_raddr1][15:0]  : 16'h0};
  assign bus.rf_rdata2 = rf_mem[bus.rf_raddr2];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, required %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic issue(input logic wr, input logic [4:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_lat, input bit push);
    int budget = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_be    = be;
    bus.cmd_wdata = wd;
    while (!bus.cmd_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) begin
      n_total++;
      $display("FAIL accept_timeout: cmd_ready stayed %0b, required 1", bus.cmd_ready);
      bus.cmd_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back('{exp_rd, exp_err, exp_lat, cyc + 1});
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    $display("cmd wr=%0b addr=%0d be=%h wdata=%h accepted at cycle %0d", wr, addr, be, wd, cyc);
  endtask

  task automatic drain();
    int budget = 0;
    while ((exp_q.size() != 0 || !bus.cmd_ready) && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) begin
      n_total++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  // Monitor: pops the scoreboard on each new response, checks stability while stalled.
  initial begin : monitor
    logic        prev_valid;
    logic [31:0] held_rdata;
    logic        held_err;
    exp_t        e;
    prev_valid = 1'b0;
    held_rdata = '0;
    held_err   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.resp_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_resp: rdata=%h err=%0b, required no response", bus.resp_rdata, bus.resp_err);
        end else begin
          e = exp_q.pop_front();
          $display("resp rdata=%h err=%0b latency=%0d", bus.resp_rdata, bus.resp_err, cyc - e.acc_cyc + 1);
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
          chk("resp_latency", cyc - e.acc_cyc + 1, e.lat);
        end
        held_rdata = bus.resp_rdata;
        held_err   = bus.resp_err;
      end else if (bus.resp_valid && prev_valid) begin
        chk("hold_rdata", bus.resp_rdata, held_rdata);
        chk("hold_err", {31'd0, bus.resp_err}, {31'd0, held_err});
        chk("hold_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      end else if (!bus.resp_valid && prev_valid && !reset) begin
        chk("resp_dropped_without_ready", {31'd0, bus.resp_ready}, 32'd1);
        chk("idle_after_resp", {31'd0, bus.cmd_ready}, 32'd1);
      end
      prev_valid = bus.resp_valid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_be     = '0;
    bus.cmd_wdata  = '0;
    bus.resp_ready = 1'b1;
    reset          = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_rf_wen", {28'd0, bus.rf_wen}, 32'd0);
    chk("rst_rf_readwen", {30'd0, bus.rf_readwen}, 32'd0);
    chk("rst_rf_waddr", {27'd0, bus.rf_waddr}, 32'd0);
    chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
    reset = 1'b0;

    // Full write then read back.
    issue(1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
    issue(1'b0, 5'd5, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
    drain();

    // Partial write over a known value.
    issue(1'b1, 5'd7, 4'hF, 32'h11223344, 32'h0, 1'b0, 2, 1'b1);
    issue(1'b1, 5'd7, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0, LAT_PART, 1'b1);
    drain();
    chk("rf7_after_partial", rf_mem[7], EXP_RF7);
    issue(1'b0, 5'd7, 4'h0, 32'h0, EXP_RF7, 1'b0, 2, 1'b1);
    drain();

    // Register 0: write rejected, read returns zero.
    issue(1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b0, 5'd0, 4'h0, 32'h0, 32'h0, 1'b0, 2, 1'b1);
    drain();

    // Empty byte mask is a one-cycle no-op.
    issue(1'b1, 5'd3, 4'hF, 32'h01020304, 32'h0, 1'b0, 2, 1'b1);
    issue(1'b1, 5'd3, 4'h0, 32'h12345678, 32'h0, 1'b0, 1, 1'b1);
    issue(1'b0, 5'd3, 4'h0, 32'h0, 32'h01020304, 1'b0, 2, 1'b1);
    drain();

    // Response back-pressure with a competing command held on the bus.
    bus.resp_ready = 1'b0;
    issue(1'b0, 5'd5, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 5'd12;
    bus.cmd_be    = 4'hF;
    bus.cmd_wdata = 32'hCAFEF00D;
    for (int k = 0; k < 7; k++) begin
      chk("stall_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    issue(1'b1, 5'd12, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1);
    issue(1'b0, 5'd12, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b1);
    drain();

    // Reset one cycle after accepting a partial write.
    issue(1'b1, 5'd9, 4'hF, 32'h55667788, 32'h0, 1'b0, 2, 1'b1);
    drain();
    issue(1'b1, 5'd9, 4'b0011, 32'h0000CAFE, 32'h0, 1'b0, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("post_reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("post_reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rf9_after_reset", rf_mem[9], EXP_RF9);
    issue(1'b0, 5'd9, 4'h0, 32'h0, EXP_RF9, 1'b0, 2, 1'b1);
    drain();

    chk("no_write_to_reg0", {31'd0, wrote0}, 32'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_rmw_master.md
Name: regfile_rmw_master

Overview:
- Command-side initiator for the 32x32 byte-write / halfword-read register file.
- Accepts read and byte-masked write commands over a valid/ready interface and drives the register file's write and read ports.
- Performs read-modify-write so that bytes outside the mask are preserved; the register file on its own zeroes every byte whose write enable is low.
- Returns read data or a write acknowledge over a valid/ready response channel. Sits between the core/debug command source and the register file.

Parameters:
- ADDR_W, 5, register address width (32 entries).
- DATA_W, 32, data width; must be 32 (4 bytes, 2 halfwords).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target register.
- cmd_be  in  4  byte mask for writes; ignored on reads.
- cmd_wdata  in  DATA_W  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_W  read data; 0 for writes.
- resp_err  out  1  write to register 0 was rejected.
- rf_wen  out  4  byte write enables to the register file.
- rf_readwen  out  2  halfword read enables.
- rf_raddr1  out  ADDR_W  read port 1 address.
- rf_raddr2  out  ADDR_W  read port 2 address; tied to 0.
- rf_waddr  out  ADDR_W  write address.
- rf_wdata  out  DATA_W  write data.
- rf_rdata1  in  DATA_W  combinational read data, port 1.
- rf_rdata2  in  DATA_W  unused.

Behaviour:
- Interface: clk and reset as listed. Reset is synchronous and active-high; there is one clock.
- The register file writes rf[waddr] on every clock edge, whether or not any enable is high. Outside the WR state the master therefore holds rf_waddr=0 and rf_wen=0, so only the unused register 0 is clobbered.
- All rf_* outputs are decoded combinationally from the state and latched-command registers. rf_readwen=2'b00 whenever no read is in progress.
- States:
  - IDLE: cmd_ready=1. A command is accepted when cmd_valid&&cmd_ready. The command is latched and the next state is chosen:
    - read -> RD.
    - write with addr==0 or be==0 -> RESP with no write; resp_err=1 when addr==0.
    - write with be==4'hF -> WR, merge register = cmd_wdata.
    - any other write -> RMW_RD.
  - RMW_RD: rf_raddr1=addr, rf_readwen=2'b11. The merge register samples (be[i] ? wdata byte i : rf_rdata1 byte i). Next state WR.
  - WR: rf_waddr=addr, rf_wen=4'hF, rf_wdata=merge register. Next state RESP.
  - RD: rf_raddr1=addr, rf_readwen=2'b11, resp_rdata register <= rf_rdata1. A read of address 0 returns 0 and does not access the file. Next state RESP.
  - RESP: resp_valid=1; resp_rdata and resp_err are held stable. When resp_ready -> IDLE.
- Latency from the accept edge to resp_valid:
  - read: 2 cycles.
  - full write: 2 cycles.
  - partial write: 3 cycles.
  - rejected/no-op write: 1 cycle.
- One command is outstanding at a time. cmd_ready=0 in every state except IDLE, so no command is accepted in the same cycle a response is consumed.
- Reset:
  - Values: state=IDLE, cmd_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, merge register=0, all rf_* outputs 0.
  - Reset asserted mid-operation aborts the operation and drops any pending response.
  - A WR-state write whose edge coincides with reset still lands, because the register file has no reset.

Optional Feature:
- Macro RMW_MERGE_EN.
- Defined: the partial-write read-modify-write path is as described above.
- Undefined: the RMW_RD state is omitted. Partial writes go IDLE -> WR with rf_wen=cmd_be, so unmasked bytes are zeroed by the register file. Partial-write latency becomes 2 cycles.

Decomposition:
- Package regfile_master_pkg holds:
  - the state enum (IDLE, RMW_RD, WR, RD, RESP);
  - constants BE_FULL=4'hF and RD_BOTH=2'b11;
  - the command/response struct typedefs.
- One natural sub-module: byte_merge, a combinational per-byte mux of new vs old data under the mask.

Test Plan:
- Full write addr 5, data 32'hDEADBEEF, then read addr 5 -> resp_rdata=32'hDEADBEEF; both responses 2 cycles after accept; resp_err=0.
- rf[7]=32'h11223344, write be=4'b0101 data 32'hAABBCCDD -> RMW_RD then WR, rf[7]=32'h11BB33DD, response at 3 cycles.
- Write addr 0 data 32'hFFFFFFFF be=4'hF -> rf_wen stays 0, resp_err=1 at 1 cycle; subsequent read of addr 0 -> 0.
- Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, cmd_ready=0, new cmd_valid ignored; resp_ready=1 -> IDLE next cycle.
- Assert reset during RMW_RD of a partial write to addr 9 -> rf[9] unchanged, resp_valid=0, cmd_ready=1 the cycle after reset.
- RMW_MERGE_EN undefined: rf[7]=32'h11223344, write be=4'b0101 data 32'hAABBCCDD -> rf[7]=32'h00BB00DD, response at 2 cycles.
